buffer_sequencer: RTL and testbench
===================================

BUFFER_SEQUENCER -- requirements
Module: buffer_sequencer

Interface
REQ-001 SHALL have parameters: ROWS, default 24, screen rows; COLS, default 80, screen columns; ROW_BITS, default 5, row index width; COL_BITS, default 7, column index width; ADDR_BITS, default 11, char buffer address width; BLANK, default 8'h20, fill character.
REQ-002 SHALL have ports:
  clk  in  1  clock
  clr  in  1  asynchronous, active-high reset
  cmd_valid  in  1  command present
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_op  in  3  opcode
  cmd_data  in  8  character or coordinate
  busy  out  1  multi-cycle operation in progress
  buffer_waddr  out  ADDR_BITS  char buffer write address
  buffer_din  out  8  char buffer write data
  buffer_wen  out  1  char buffer write strobe
  buffer_first_char  out  ADDR_BITS  scroll origin
  buffer_first_char_wen  out  1  scroll origin strobe
  new_cursor_x  out  COL_BITS  cursor column
  new_cursor_y  out  ROW_BITS  cursor row
  new_cursor_wen  out  1  cursor strobe

Function
REQ-003 SHALL implement the FSM states IDLE, CLEAR and SCROLL, with cmd_ready = (state==IDLE) and busy = !cmd_ready.
REQ-004 SHALL accept a command on a rising clk edge where cmd_valid && cmd_ready; all outputs SHALL be registered and SHALL take effect in the cycle after acceptance.
REQ-005 SHALL compute the physical address as (first_char + y*COLS + x) mod (ROWS*COLS), using a single conditional subtraction of ROWS*COLS; no intermediate value SHALL overflow ADDR_BITS+1 bits.
REQ-006 SHALL implement op 0 NOP with no output strobes.
REQ-007 SHALL implement op 1 PUTC: write cmd_data at the cursor address (one-cycle buffer_wen), then x+1, with x saturating at COLS-1; new_cursor_wen pulses in the same cycle as the write.
REQ-008 SHALL implement op 2 LF: if y<ROWS-1, set y+1 and pulse new_cursor_wen; if y==ROWS-1, enter SCROLL.
REQ-009 SHALL implement op 3 CR: set x=0 and pulse new_cursor_wen.
REQ-010 SHALL implement op 4 GOTO_X and op 5 GOTO_Y: set x or y to cmd_data, clamped to COLS-1 or ROWS-1 respectively, and pulse new_cursor_wen.
REQ-011 SHALL implement op 6 CLR_EOL: enter CLEAR, writing BLANK at cells x..COLS-1 of row y, one per cycle; the cursor is unchanged.
REQ-012 SHALL implement op 7 CLR_SCREEN: enter CLEAR, writing BLANK at physical addresses 0..ROWS*COLS-1, one per cycle, then pulse buffer_first_char_wen with value 0 and new_cursor_wen with (0,0) in the cycle after the last write.
REQ-013 SCROLL SHALL, in its first cycle, pulse buffer_first_char_wen with first_char+COLS, wrapping to 0 when that value equals ROWS*COLS.
REQ-014 SCROLL SHALL, in the following COLS cycles, write BLANK at the old first_char..old first_char+COLS-1; the cursor is unchanged.
REQ-015 At the end of CLEAR or SCROLL, the FSM SHALL return to IDLE; cmd_ready SHALL rise in the cycle after the last write.
REQ-016 buffer_wen, buffer_first_char_wen and new_cursor_wen SHALL be single-cycle pulses, low in every other cycle.
REQ-017 A command presented while busy SHALL NOT be accepted, and the requester SHALL hold cmd_valid, cmd_op and cmd_data stable until accepted.
REQ-018 Back-to-back single-cycle commands (ops 0-5 without scroll) SHALL be accepted on consecutive cycles.

Reset
REQ-019 On clr SHALL set: cursor (0,0); first_char 0; buffer_waddr 0; buffer_din 0; all strobes 0; state CLEAR (full screen, as op 7).
REQ-020 The first BLANK write SHALL occur in the first cycle after clr deasserts; cmd_ready SHALL be 0 for ROWS*COLS+1 cycles.
REQ-021 clr asserted mid-operation SHALL abort the operation immediately and restart per REQ-019.

Verification
REQ-022 Release reset -> 1920 writes of 0x20 at addresses 0..1919 in order, then first_char 0 and cursor (0,0) strobes, then cmd_ready=1.
REQ-023 PUTC 0x41 at (0,0) -> next cycle waddr=0, din=0x41, wen=1, cursor x=1; PUTC at x=79 -> write at address 79, cursor x stays 79.
REQ-024 GOTO_Y 23, then LF -> buffer_first_char=80 strobe, then 80 writes at addresses 0..79, cursor y=23; repeat with first_char=1840 -> buffer_first_char=0, writes at 1840..1919.
REQ-025 With first_char=1840, GOTO_Y 1, GOTO_X 5, then PUTC -> waddr=5; GOTO_X 200 -> x=79.
REQ-026 CLR_EOL at (70,2) with cmd_valid held high -> 10 writes at 230..239, next command accepted in the cycle after the last write; clr asserted during the 5th write -> all strobes 0 immediately, full clear restarts.

Source files
------------

// File: rtl/buffer_sequencer.sv
// Character-buffer command sequencer: cursor moves, character writes, line/screen clears and scrolling.
// Outputs are registered, one cycle after acceptance; cmd_ready is low while a CLEAR or SCROLL sweep runs.
module buffer_sequencer #(
    parameter int          ROWS      = 24,
    parameter int          COLS      = 80,
    parameter int          ROW_BITS  = 5,
    parameter int          COL_BITS  = 7,
    parameter int          ADDR_BITS = 11,
    parameter logic [7:0]  BLANK     = 8'h20
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [7:0]           cmd_data,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] buffer_waddr,
    output logic [7:0]           buffer_din,
    output logic                 buffer_wen,
    output logic [ADDR_BITS-1:0] buffer_first_char,
    output logic                 buffer_first_char_wen,
    output logic [COL_BITS-1:0]  new_cursor_x,
    output logic [ROW_BITS-1:0]  new_cursor_y,
    output logic                 new_cursor_wen
);
    localparam logic [ADDR_BITS:0]   CELLS_W = (ADDR_BITS+1)'(ROWS * COLS);
    localparam logic [ADDR_BITS:0]   COLS_W  = (ADDR_BITS+1)'(COLS);
    localparam logic [COL_BITS-1:0]  X_MAX   = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0]  Y_MAX   = ROW_BITS'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [COL_BITS-1:0]    r_x;
    logic [ROW_BITS-1:0]    r_y;
    logic [ADDR_BITS-1:0]   r_fc;
    logic [ADDR_BITS-1:0]   r_cnt;
    logic [ADDR_BITS-1:0]   r_stop;
    logic                   r_full;
    logic [ADDR_BITS-1:0]   r_waddr;
    logic [7:0]             r_din;
    logic                   r_wen;
    logic                   r_fc_wen;
    logic                   r_cur_wen;

    logic [ADDR_BITS:0]     w_row_off;
    logic [ADDR_BITS:0]     w_sum;
    logic [ADDR_BITS-1:0]   w_addr;
    logic [ADDR_BITS-1:0]   w_row_stop;
    logic [ADDR_BITS:0]     w_fc_inc;
    logic [ADDR_BITS-1:0]   w_fc_next;
    logic [COL_BITS-1:0]    w_goto_x;
    logic [ROW_BITS-1:0]    w_goto_y;

    // fc < CELLS and y*COLS+x < CELLS, so one conditional subtraction wraps the sum.
    assign w_row_off  = (ADDR_BITS+1)'(r_y) * COLS_W;
    assign w_sum      = {1'b0, r_fc} + w_row_off + (ADDR_BITS+1)'(r_x);
    assign w_addr     = (w_sum >= CELLS_W) ? ADDR_BITS'(w_sum - CELLS_W) : ADDR_BITS'(w_sum);
    // first_char is always a multiple of COLS, so a row never straddles the wrap point.
    assign w_row_stop = w_addr - ADDR_BITS'(r_x) + ADDR_BITS'(COLS);
    assign w_fc_inc   = {1'b0, r_fc} + COLS_W;
    assign w_fc_next  = (w_fc_inc == CELLS_W) ? '0 : ADDR_BITS'(w_fc_inc);
    assign w_goto_x   = (cmd_data > 8'(COLS - 1)) ? X_MAX : COL_BITS'(cmd_data);
    assign w_goto_y   = (cmd_data > 8'(ROWS - 1)) ? Y_MAX : ROW_BITS'(cmd_data);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_CLEAR;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        3'd2:       if (r_y == Y_MAX) w_next = S_SCROLL;
                        3'd6, 3'd7: w_next = S_CLEAR;
                        default:    w_next = S_IDLE;
                    endcase
                end
            end
            default: if (r_cnt == r_stop) w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_x <= '0; r_y <= '0; r_fc <= '0;
            r_cnt <= '0; r_stop <= ADDR_BITS'(CELLS_W); r_full <= 1'b1;
            r_waddr <= '0; r_din <= '0;
            r_wen <= 1'b0; r_fc_wen <= 1'b0; r_cur_wen <= 1'b0;
        end else begin
            r_wen     <= 1'b0;
            r_fc_wen  <= 1'b0;
            r_cur_wen <= 1'b0;
            if (r_state == S_IDLE) begin
                if (cmd_valid) begin
                    case (cmd_op)
                        3'd1: begin
                            r_waddr <= w_addr; r_din <= cmd_data; r_wen <= 1'b1;
                            if (r_x != X_MAX) r_x <= r_x + COL_BITS'(1);
                            r_cur_wen <= 1'b1;
                        end
                        3'd2: begin
                            if (r_y != Y_MAX) begin
                                r_y <= r_y + ROW_BITS'(1); r_cur_wen <= 1'b1;
                            end else begin
                                r_fc <= w_fc_next; r_fc_wen <= 1'b1;
                                r_cnt <= r_fc; r_stop <= ADDR_BITS'(w_fc_inc); r_full <= 1'b0;
                            end
                        end
                        3'd3: begin r_x <= '0;       r_cur_wen <= 1'b1; end
                        3'd4: begin r_x <= w_goto_x; r_cur_wen <= 1'b1; end
                        3'd5: begin r_y <= w_goto_y; r_cur_wen <= 1'b1; end
                        3'd6: begin
                            r_waddr <= w_addr; r_din <= BLANK; r_wen <= 1'b1;
                            r_cnt <= w_addr + ADDR_BITS'(1); r_stop <= w_row_stop; r_full <= 1'b0;
                        end
                        3'd7: begin
                            r_waddr <= '0; r_din <= BLANK; r_wen <= 1'b1;
                            r_cnt <= ADDR_BITS'(1); r_stop <= ADDR_BITS'(CELLS_W); r_full <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (r_cnt != r_stop) begin
                r_waddr <= r_cnt; r_din <= BLANK; r_wen <= 1'b1;
                r_cnt <= r_cnt + ADDR_BITS'(1);
            end else if (r_full) begin
                r_fc <= '0; r_fc_wen <= 1'b1;
                r_x <= '0; r_y <= '0; r_cur_wen <= 1'b1;
            end
        end
    end

    assign buffer_waddr          = r_waddr;
    assign buffer_din            = r_din;
    assign buffer_wen            = r_wen;
    assign buffer_first_char     = r_fc;
    assign buffer_first_char_wen = r_fc_wen;
    assign new_cursor_x          = r_x;
    assign new_cursor_y          = r_y;
    assign new_cursor_wen        = r_cur_wen;
endmodule

// File: tb/tb_buffer_sequencer.sv
// Directed bench for buffer_sequencer: reset clear, PUTC, cursor ops, CLR_EOL, abort, scrolling.
module tb_buffer_sequencer;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        busy;
    logic [10:0] buffer_waddr;
    logic [7:0]  buffer_din;
    logic        buffer_wen;
    logic [10:0] buffer_first_char;
    logic        buffer_first_char_wen;
    logic [6:0]  new_cursor_x;
    logic [4:0]  new_cursor_y;
    logic        new_cursor_wen;

    int checks = 0;
    int errors = 0;

    buffer_sequencer dut (
        .clk(clk), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .busy(busy),
        .buffer_waddr(buffer_waddr), .buffer_din(buffer_din), .buffer_wen(buffer_wen),
        .buffer_first_char(buffer_first_char), .buffer_first_char_wen(buffer_first_char_wen),
        .new_cursor_x(new_cursor_x), .new_cursor_y(new_cursor_y), .new_cursor_wen(new_cursor_wen)
    );

    always #5 clk = ~clk;

    // Present a command and return #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] d);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL send_timeout: cmd_ready %0b expected 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Called with clr just released at a negedge.
    task automatic check_full_clear(input string name);
        int bad; int first_bad;
        bad = 0; first_bad = -1;
        for (int i = 0; i < 1920; i++) begin
            @(posedge clk); #1;
            if (buffer_wen !== 1'b1 || buffer_waddr !== 11'(i) || buffer_din !== 8'h20 ||
                cmd_ready !== 1'b0 || buffer_first_char_wen !== 1'b0 || new_cursor_wen !== 1'b0) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL %s_writes: %0d bad cycles, first at %0d (addr %0d) expected 0", name, bad, first_bad, buffer_waddr);
        end
        @(posedge clk); #1;
        checks++;
        if (buffer_first_char_wen !== 1'b1 || buffer_first_char !== 11'd0 || new_cursor_wen !== 1'b1 ||
            new_cursor_x !== 7'd0 || new_cursor_y !== 5'd0 || cmd_ready !== 1'b1 || buffer_wen !== 1'b0) begin
            errors++;
            $display("FAIL %s_final: fcw %0b fc %0d cw %0b x %0d y %0d rdy %0b wen %0b expected 1 0 1 0 0 1 0",
                     name, buffer_first_char_wen, buffer_first_char, new_cursor_wen, new_cursor_x, new_cursor_y, cmd_ready, buffer_wen);
        end
        @(posedge clk); #1;
        checks++;
        if (buffer_first_char_wen !== 1'b0 || new_cursor_wen !== 1'b0 || buffer_wen !== 1'b0) begin
            errors++; $display("FAIL %s_pulse: fcw %0b cw %0b wen %0b expected 0 0 0", name, buffer_first_char_wen, new_cursor_wen, buffer_wen);
        end
    endtask

    // Called right after an LF at the bottom row is accepted.
    task automatic scroll_check(input int old_fc, input int new_fc);
        int bad; int first_bad;
        checks++;
        if (buffer_first_char_wen !== 1'b1 || buffer_first_char !== 11'(new_fc) || buffer_wen !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL scroll_origin: fcw %0b fc %0d wen %0b rdy %0b expected 1 %0d 0 0",
                               buffer_first_char_wen, buffer_first_char, buffer_wen, cmd_ready, new_fc);
        end
        bad = 0; first_bad = -1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (buffer_wen !== 1'b1 || buffer_waddr !== 11'(old_fc + i) || buffer_din !== 8'h20 ||
                cmd_ready !== 1'b0 || buffer_first_char_wen !== 1'b0) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL scroll_writes: %0d bad cycles, first at %0d expected 0", bad, first_bad);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || buffer_wen !== 1'b0 || new_cursor_y !== 5'd23 || new_cursor_wen !== 1'b0) begin
            errors++; $display("FAIL scroll_end: rdy %0b wen %0b y %0d cw %0b expected 1 0 23 0",
                               cmd_ready, buffer_wen, new_cursor_y, new_cursor_wen);
        end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if (buffer_wen !== 1'b0 || buffer_first_char_wen !== 1'b0 || new_cursor_wen !== 1'b0 ||
            cmd_ready !== 1'b0 || busy !== 1'b1 || buffer_waddr !== 11'd0 || buffer_din !== 8'd0 ||
            new_cursor_x !== 7'd0 || new_cursor_y !== 5'd0 || buffer_first_char !== 11'd0) begin
            errors++; $display("FAIL reset_state: wen %0b rdy %0b busy %0b addr %0d din %0h x %0d y %0d expected 0 0 1 0 0 0 0",
                               buffer_wen, cmd_ready, busy, buffer_waddr, buffer_din, new_cursor_x, new_cursor_y);
        end
        @(negedge clk); clr = 1'b0;
        check_full_clear("reset_clear");
    endtask

    task automatic test_putc();
        send(3'd1, 8'h41);
        checks++;
        if (buffer_waddr !== 11'd0 || buffer_din !== 8'h41 || buffer_wen !== 1'b1 || new_cursor_wen !== 1'b1 || new_cursor_x !== 7'd1) begin
            errors++; $display("FAIL putc_first: addr %0d din %0h wen %0b cw %0b x %0d expected 0 41 1 1 1",
                               buffer_waddr, buffer_din, buffer_wen, new_cursor_wen, new_cursor_x);
        end
        @(posedge clk); #1;
        checks++;
        if (buffer_wen !== 1'b0 || new_cursor_wen !== 1'b0) begin
            errors++; $display("FAIL putc_pulse: wen %0b cw %0b expected 0 0", buffer_wen, new_cursor_wen);
        end
        send(3'd4, 8'd79);
        send(3'd1, 8'h42);
        checks++;
        if (buffer_waddr !== 11'd79 || buffer_din !== 8'h42 || buffer_wen !== 1'b1 || new_cursor_x !== 7'd79) begin
            errors++; $display("FAIL putc_sat: addr %0d din %0h wen %0b x %0d expected 79 42 1 79",
                               buffer_waddr, buffer_din, buffer_wen, new_cursor_x);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [6]  = '{3'd4, 3'd5, 3'd3, 3'd2, 3'd0, 3'd5};
        logic [7:0] dat [6]  = '{8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd50};
        int         ex  [6]  = '{3, 3, 0, 0, 0, 0};
        int         ey  [6]  = '{0, 4, 4, 5, 5, 23};
        logic       ecw [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_op = ops[i]; cmd_data = dat[i]; cmd_valid = 1'b1;
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: cmd_ready %0b expected 1", i, cmd_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (new_cursor_x !== 7'(ex[i]) || new_cursor_y !== 5'(ey[i]) || new_cursor_wen !== ecw[i] || buffer_wen !== 1'b0) begin
                errors++; $display("FAIL b2b_cursor[%0d]: x %0d y %0d cw %0b wen %0b expected %0d %0d %0b 0",
                                   i, new_cursor_x, new_cursor_y, new_cursor_wen, buffer_wen, ex[i], ey[i], ecw[i]);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_clr_eol();
        int bad;
        send(3'd4, 8'd70);
        send(3'd5, 8'd2);
        @(negedge clk);
        cmd_op = 3'd6; cmd_data = 8'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = 3'd4; cmd_data = 8'd5;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (buffer_wen !== 1'b1 || buffer_waddr !== 11'(230 + i) || buffer_din !== 8'h20 ||
                cmd_ready !== 1'b0 || new_cursor_wen !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL eol_writes: %0d bad cycles expected 0", bad);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || buffer_wen !== 1'b0 || new_cursor_x !== 7'd70 || new_cursor_y !== 5'd2) begin
            errors++; $display("FAIL eol_end: rdy %0b wen %0b x %0d y %0d expected 1 0 70 2",
                               cmd_ready, buffer_wen, new_cursor_x, new_cursor_y);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (new_cursor_wen !== 1'b1 || new_cursor_x !== 7'd5) begin
            errors++; $display("FAIL eol_next_cmd: cw %0b x %0d expected 1 5", new_cursor_wen, new_cursor_x);
        end
    endtask

    task automatic test_clr_abort();
        send(3'd6, 8'd0);
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        checks++;
        if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd169) begin
            errors++; $display("FAIL abort_fifth: wen %0b addr %0d expected 1 169", buffer_wen, buffer_waddr);
        end
        clr = 1'b1;
        #1;
        checks++;
        if (buffer_wen !== 1'b0 || buffer_first_char_wen !== 1'b0 || new_cursor_wen !== 1'b0 ||
            buffer_waddr !== 11'd0 || cmd_ready !== 1'b0 || new_cursor_x !== 7'd0 || new_cursor_y !== 5'd0) begin
            errors++; $display("FAIL abort_reset: wen %0b fcw %0b cw %0b addr %0d rdy %0b x %0d y %0d expected 0 0 0 0 0 0 0",
                               buffer_wen, buffer_first_char_wen, new_cursor_wen, buffer_waddr, cmd_ready, new_cursor_x, new_cursor_y);
        end
        @(negedge clk); clr = 1'b0;
        check_full_clear("abort_clear");
    endtask

    task automatic test_scroll();
        send(3'd5, 8'd23);
        send(3'd2, 8'd0);
        scroll_check(0, 80);
        for (int i = 0; i < 22; i++) send(3'd2, 8'd0);
        send(3'd5, 8'd1);
        checks++;
        if (buffer_first_char !== 11'd1840 || new_cursor_y !== 5'd1) begin
            errors++; $display("FAIL scroll_origin_1840: fc %0d y %0d expected 1840 1", buffer_first_char, new_cursor_y);
        end
        send(3'd4, 8'd5);
        send(3'd1, 8'h43);
        checks++;
        if (buffer_waddr !== 11'd5 || buffer_wen !== 1'b1 || buffer_din !== 8'h43) begin
            errors++; $display("FAIL wrap_addr: addr %0d wen %0b din %0h expected 5 1 43", buffer_waddr, buffer_wen, buffer_din);
        end
        send(3'd4, 8'd200);
        checks++;
        if (new_cursor_x !== 7'd79 || new_cursor_wen !== 1'b1) begin
            errors++; $display("FAIL goto_x_clamp: x %0d cw %0b expected 79 1", new_cursor_x, new_cursor_wen);
        end
        send(3'd5, 8'd23);
        send(3'd2, 8'd0);
        scroll_check(1840, 0);
    endtask

    initial begin
        test_reset();
        test_putc();
        test_back_to_back();
        test_clr_eol();
        test_clr_abort();
        test_scroll();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
